// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame geometry and line levels.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    // Serial line levels
    localparam logic UART_IDLE  = 1'b1;
    localparam logic UART_START = 1'b0;

    // Transmit engine states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Single-clock FIFO feeding the UART transmit engine.
// Full/empty/level are registered and derived from the same next-level value,
// so they always agree. A push while full is refused even if a pop happens
// in the same cycle; a pop while empty is ignored.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = UART_DATA_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic [LW-1:0]    level_next_s;
    logic             full_r;
    logic             empty_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push & ~full_r;
    assign pop_ok_s  = pop & ~empty_r;
    assign pop_data  = mem_r[rd_ptr_r];
    assign full      = full_r;
    assign empty     = empty_r;
    assign level     = level_r;

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        level_next_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_next_s = level_r + LW'(1);
            2'b01:   level_next_s = level_r - LW'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Storage array write port (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and registered occupancy flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_next_s;
            full_r  <= (level_next_s == LW'(DEPTH));
            empty_r <= (level_next_s == LW'(0));
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: bytes written into a FIFO are sent as 8N1
// frames, LSB first. A new frame is popped on the last STOP cycle when data
// is waiting, so back-to-back frames have no idle gap. tx and busy are
// registered from the next-state decode, so they follow the FSM with no
// extra cycle of delay.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                     UART_CLK,
    input  logic                     reset,
    input  logic                     write_req,
    input  logic [7:0]               write_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     busy,
    output logic                     tx
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] CNT_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(UART_DATA_BITS - 1);

    uart_tx_state_e              state_r;
    uart_tx_state_e              state_next_s;
    logic [CW-1:0]               cnt_r;
    logic [CW-1:0]               cnt_next_s;
    logic [IW-1:0]               idx_r;
    logic [IW-1:0]               idx_next_s;
    logic [UART_DATA_BITS-1:0]   shift_r;
    logic [UART_DATA_BITS-1:0]   shift_next_s;
    logic                        tx_r;
    logic                        tx_next_s;
    logic                        busy_r;
    logic                        overflow_r;
    logic                        pop_s;
    logic                        fifo_full_s;
    logic                        fifo_empty_s;
    logic [UART_DATA_BITS-1:0]   fifo_head_s;

    uart_tx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk       (UART_CLK),
        .rst_n     (reset),
        .push      (write_req),
        .push_data (write_data),
        .pop       (pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s),
        .level     (level)
    );

    assign full     = fifo_full_s;
    assign empty    = fifo_empty_s;
    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

    // Frame sequencing: next state, bit timing, shift register and pops
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        pop_s        = 1'b0;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = fifo_head_s;
                    cnt_next_s   = CNT_LOAD;
                    state_next_s = START;
                end else begin
                    state_next_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == CW'(0)) begin
                    cnt_next_s   = CNT_LOAD;
                    idx_next_s   = IW'(0);
                    state_next_s = DATA;
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            DATA: begin
                if (cnt_r == CW'(0)) begin
                    cnt_next_s   = CNT_LOAD;
                    shift_next_s = shift_r >> 1;
                    if (idx_r == IDX_LAST) begin
                        state_next_s = STOP;
                    end else begin
                        idx_next_s = idx_r + IW'(1);
                    end
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            STOP: begin
                if (cnt_r == CW'(0)) begin
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = fifo_head_s;
                        cnt_next_s   = CNT_LOAD;
                        state_next_s = START;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    cnt_next_s = cnt_r - CW'(1);
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Line level for the cycle following this edge
    always_comb begin
        tx_next_s = UART_IDLE;
        case (state_next_s)
            START:   tx_next_s = UART_START;
            DATA:    tx_next_s = shift_next_s[0];
            default: tx_next_s = UART_IDLE;
        endcase
    end

    // FSM, counters and registered line/status outputs
    always_ff @(posedge UART_CLK or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            cnt_r      <= CW'(0);
            idx_r      <= IW'(0);
            shift_r    <= UART_DATA_BITS'(0);
            tx_r       <= UART_IDLE;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            idx_r      <= idx_next_s;
            shift_r    <= shift_next_s;
            tx_r       <= tx_next_s;
            busy_r     <= (state_next_s != IDLE);
            overflow_r <= write_req & fifo_full_s;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered (DEPTH=16, CLKS_PER_BIT=4).
// Accepted bytes are queued on the write side; a serial monitor decodes tx
// frames and compares each one with the queue head.
module tb_uart_tx_buffered;

    localparam int DEPTH = 16;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk;
    logic        reset;
    logic        write_req;
    logic [7:0]  write_data;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        overflow;
    logic        busy;
    logic        tx;

    int          checks;
    int          failures;
    logic [7:0]  exp_q[$];
    logic        ovf_exp;
    int          run_len;
    int          last_run;
    bit          run_done;
    int          lvl_peak;

    uart_tx_buffered #(
        .DEPTH        (DEPTH),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .UART_CLK   (clk),
        .reset      (reset),
        .write_req  (write_req),
        .write_data (write_data),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .overflow   (overflow),
        .busy       (busy),
        .tx         (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock of stimulus; inputs change 1 time unit after the rising edge
    task automatic drive_cycle(input logic req, input logic [7:0] d, input bit drop);
        write_req  = req;
        write_data = d;
        @(posedge clk);
        #1;
        ovf_exp   = req & drop;
        if (req && !drop) exp_q.push_back(d);
        write_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int bound);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            @(negedge clk);
            if (run_done && !busy && empty && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        chk({name, "_drained"}, 32'(ok), 32'(1));
    endtask

    // Serial monitor: decode frames and compare against the scoreboard
    initial begin
        logic s [FRAME];
        logic [7:0] d;
        bit aborted;
        bit shape_ok;
        bit busy_ok;
        forever begin
            @(negedge clk);
            if (reset && tx == 1'b0) begin
                aborted = 1'b0;
                s[0]    = tx;
                busy_ok = busy;
                for (int k = 1; k < FRAME; k++) begin
                    @(negedge clk);
                    if (!reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    s[k]    = tx;
                    busy_ok = busy_ok & busy;
                end
                if (!aborted) begin
                    shape_ok = (s[0] == 1'b0) && (s[FRAME-CPB] == 1'b1);
                    for (int b = 0; b < 10; b++)
                        for (int c = 1; c < CPB; c++)
                            if (s[b*CPB+c] !== s[b*CPB]) shape_ok = 1'b0;
                    for (int b = 0; b < 8; b++) d[b] = s[(b+1)*CPB];
                    chk("frame_shape", 32'(shape_ok), 32'(1));
                    chk("frame_busy", 32'(busy_ok), 32'(1));
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
                    end else begin
                        chk("frame_data", 32'(d), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    // Status monitor: overflow pulses, flag consistency, busy runs, level peak
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                run_len = 0;
            end else begin
                chk("overflow", 32'(overflow), 32'(ovf_exp));
                chk("empty_vs_level", 32'(empty), 32'(level == 5'd0));
                chk("full_vs_level", 32'(full), 32'(level == 5'(DEPTH)));
                if (32'(level) > lvl_peak) lvl_peak = 32'(level);
                if (busy) begin
                    run_len++;
                end else if (run_len > 0) begin
                    last_run = run_len;
                    run_done = 1'b1;
                    run_len  = 0;
                end
            end
        end
    end

    // Global time limit
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int sent;
        int budget;
        bit act;
        checks     = 0;
        failures   = 0;
        ovf_exp    = 1'b0;
        run_len    = 0;
        last_run   = 0;
        run_done   = 1'b0;
        lvl_peak   = 0;
        reset      = 1'b0;
        write_req  = 1'b0;
        write_data = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'(1));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_full", 32'(full), 32'(0));
        chk("rst_empty", 32'(empty), 32'(1));
        chk("rst_level", 32'(level), 32'(0));
        @(posedge clk);
        #1;

        // Single byte: one cycle of latency, 40-cycle frame
        run_done = 1'b0;
        drive_cycle(1'b1, 8'hA5, 1'b0);
        @(negedge clk);
        chk("single_level_after_write", 32'(level), 32'(1));
        chk("single_tx_before_start", 32'(tx), 32'(1));
        drive_cycle(1'b0, 8'h00, 1'b0);
        @(negedge clk);
        chk("single_tx_start", 32'(tx), 32'(0));
        chk("single_busy_start", 32'(busy), 32'(1));
        chk("single_level_after_pop", 32'(level), 32'(0));
        wait_idle("single", 200);
        chk("single_busy_len", 32'(last_run), 32'(FRAME));
        chk("single_level_end", 32'(level), 32'(0));

        // Burst of three back-to-back writes
        run_done = 1'b0;
        lvl_peak = 0;
        drive_cycle(1'b1, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'hFF, 1'b0);
        drive_cycle(1'b1, 8'h3C, 1'b0);
        wait_idle("burst", 400);
        chk("burst_level_peak", 32'(lvl_peak), 32'(2));
        chk("burst_busy_len", 32'(last_run), 32'(3 * FRAME));

        // Overflow: fill the FIFO during a frame, 17th write is dropped
        run_done = 1'b0;
        drive_cycle(1'b1, 8'($urandom), 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
        @(negedge clk);
        chk("ovf_full", 32'(full), 32'(1));
        chk("ovf_level", 32'(level), 32'(DEPTH));
        drive_cycle(1'b1, 8'hEE, 1'b1);
        @(negedge clk);
        chk("ovf_level_unchanged", 32'(level), 32'(DEPTH));
        wait_idle("ovf", 2000);
        chk("ovf_busy_len", 32'(last_run), 32'((DEPTH + 1) * FRAME));

        // Wrap-around: random pacing, never more than DEPTH outstanding
        sent   = 0;
        budget = 0;
        while (sent < 40 && budget < 20000) begin
            if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 0) begin
                drive_cycle(1'b1, 8'(sent), 1'b0);
                sent++;
            end else begin
                drive_cycle(1'b0, 8'h00, 1'b0);
            end
            budget++;
        end
        chk("wrap_all_sent", 32'(sent), 32'(40));
        run_done = 1'b0;
        wait_idle("wrap", 3000);

        // Simultaneous push on the STOP->START pop edge
        drive_cycle(1'b1, 8'h5A, 1'b0);
        drive_cycle(1'b0, 8'h00, 1'b0);
        drive_cycle(1'b1, 8'hC3, 1'b0);
        idle(FRAME - 2);
        @(negedge clk);
        chk("pp_level_before", 32'(level), 32'(1));
        chk("pp_in_stop", 32'(tx), 32'(1));
        drive_cycle(1'b1, 8'h96, 1'b0);
        @(negedge clk);
        chk("pp_level_after", 32'(level), 32'(1));
        chk("pp_new_start", 32'(tx), 32'(0));
        run_done = 1'b0;
        wait_idle("pp", 400);

        // Reset in DATA bit 3 with five bytes queued
        for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'($urandom), 1'b0);
        idle(12);
        #3 reset = 1'b0;
        #1;
        chk("rstmid_tx", 32'(tx), 32'(1));
        chk("rstmid_busy", 32'(busy), 32'(0));
        chk("rstmid_level", 32'(level), 32'(0));
        chk("rstmid_empty", 32'(empty), 32'(1));
        exp_q.delete();
        ovf_exp = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 60; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) act = 1'b1;
        end
        chk("rstmid_quiet", 32'(act), 32'(0));
        run_done = 1'b0;
        drive_cycle(1'b1, 8'h81, 1'b0);
        wait_idle("post_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
